// File: rtl/nmr_seg_sequencer.sv
// Segment sequencer for the 5 kHz long-delay timer: walks a table of per-segment
// delays for scan_count scans, arming the timer for every non-zero entry.
module nmr_seg_sequencer #(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = 2,
  parameter int PARA_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [SEG_W-1:0]  cfg_addr,
  input  logic [PARA_W-1:0] cfg_data,
  input  logic [15:0]       scan_count,
  input  logic              go,
  input  logic              abort,
  input  logic              timeup,
  output logic              timer_start,
  output logic [PARA_W-1:0] timer_para,
  output logic [SEG_W-1:0]  seg_idx,
  output logic              busy,
  output logic              seg_done,
  output logic              scan_done,
  output logic              aborted,
  output logic [15:0]       scans_left
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

  logic [2:0]        state_q, state_d;
  logic [PARA_W-1:0] seg_tbl_q [NUM_SEG];
  logic [PARA_W-1:0] seg_tbl_d [NUM_SEG];
  logic              timer_start_q, timer_start_d;
  logic [PARA_W-1:0] timer_para_q, timer_para_d;
  logic [SEG_W-1:0]  seg_idx_q, seg_idx_d;
  logic              busy_q, busy_d;
  logic              seg_done_q, seg_done_d;
  logic              scan_done_q, scan_done_d;
  logic              aborted_q, aborted_d;
  logic [15:0]       scans_left_q, scans_left_d;
  logic [PARA_W-1:0] cur_entry_s;

  assign cur_entry_s = seg_tbl_q[seg_idx_q];

  // Next-state logic: table writes, sequencing FSM and abort override.
  always_comb begin
    seg_tbl_d     = seg_tbl_q;
    state_d       = state_q;
    timer_start_d = timer_start_q;
    timer_para_d  = timer_para_q;
    seg_idx_d     = seg_idx_q;
    busy_d        = busy_q;
    seg_done_d    = 1'b0;
    scan_done_d   = 1'b0;
    aborted_d     = 1'b0;
    scans_left_d  = scans_left_q;

    // Configuration is frozen while a sequence runs so the table stays coherent.
    if (cfg_we && !busy_q && (int'(cfg_addr) < NUM_SEG)) begin
      seg_tbl_d[cfg_addr] = cfg_data;
    end else begin
      seg_tbl_d = seg_tbl_q;
    end

    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      timer_start_d = 1'b0;
      busy_d        = 1'b0;
      aborted_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go && (scan_count != 16'd0)) begin
            state_d      = ST_LOAD;
            scans_left_d = scan_count;
            seg_idx_d    = {SEG_W{1'b0}};
            busy_d       = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          timer_para_d = cur_entry_s;
          if (cur_entry_s == {PARA_W{1'b0}}) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          timer_start_d = 1'b1;
          state_d       = ST_WAIT;
        end
        ST_WAIT: begin
          if (timeup) begin
            timer_start_d = 1'b0;
            seg_done_d    = 1'b1;
            state_d       = ST_NEXT;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_NEXT: begin
          timer_start_d = 1'b0;
          if (seg_idx_q != LAST_SEG) begin
            seg_idx_d = seg_idx_q + {{(SEG_W-1){1'b0}}, 1'b1};
            state_d   = ST_LOAD;
          end else if (scans_left_q > 16'd1) begin
            scans_left_d = scans_left_q - 16'd1;
            seg_idx_d    = {SEG_W{1'b0}};
            state_d      = ST_LOAD;
          end else begin
            scans_left_d = 16'd0;
            state_d      = ST_DONE;
          end
        end
        ST_DONE: begin
          scan_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d       = ST_IDLE;
          timer_start_d = 1'b0;
          busy_d        = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      timer_start_q <= 1'b0;
      timer_para_q  <= {PARA_W{1'b0}};
      seg_idx_q     <= {SEG_W{1'b0}};
      busy_q        <= 1'b0;
      seg_done_q    <= 1'b0;
      scan_done_q   <= 1'b0;
      aborted_q     <= 1'b0;
      scans_left_q  <= 16'd0;
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_tbl_q[i] <= {PARA_W{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      timer_start_q <= timer_start_d;
      timer_para_q  <= timer_para_d;
      seg_idx_q     <= seg_idx_d;
      busy_q        <= busy_d;
      seg_done_q    <= seg_done_d;
      scan_done_q   <= scan_done_d;
      aborted_q     <= aborted_d;
      scans_left_q  <= scans_left_d;
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_tbl_q[i] <= seg_tbl_d[i];
      end
    end
  end

  assign timer_start = timer_start_q;
  assign timer_para  = timer_para_q;
  assign seg_idx     = seg_idx_q;
  assign busy        = busy_q;
  assign seg_done    = seg_done_q;
  assign scan_done   = scan_done_q;
  assign aborted     = aborted_q;
  assign scans_left  = scans_left_q;

endmodule

// File: tb/tb_nmr_seg_sequencer.sv
// Self-checking bench for nmr_seg_sequencer: a behavioural long-timer model plus an
// expected list of armed segments built from the table and scan count.
module tb_nmr_seg_sequencer;
  localparam int NUM_SEG = 4;
  localparam int SEG_W   = 2;
  localparam int PARA_W  = 16;

  logic              clk_sys = 1'b0;
  logic              rst_n, cfg_we, go, abort, timeup;
  logic [SEG_W-1:0]  cfg_addr;
  logic [PARA_W-1:0] cfg_data;
  logic [15:0]       scan_count;
  logic              timer_start, busy, seg_done, scan_done, aborted;
  logic [PARA_W-1:0] timer_para;
  logic [SEG_W-1:0]  seg_idx;
  logic [15:0]       scans_left;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;
  int done_cyc;
  logic [PARA_W-1:0] tbl [NUM_SEG];
  int exp_idx[$];
  int exp_para[$];
  int exp_scn[$];

  nmr_seg_sequencer #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .PARA_W(PARA_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .scan_count(scan_count), .go(go), .abort(abort),
    .timeup(timeup), .timer_start(timer_start), .timer_para(timer_para),
    .seg_idx(seg_idx), .busy(busy), .seg_done(seg_done), .scan_done(scan_done),
    .aborted(aborted), .scans_left(scans_left)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Long timer: counts while enabled, expires after para+1 ticks, clears when disabled.
  task automatic timer_step();
    if (timer_start) begin
      tcnt++;
      timeup = (tcnt >= int'(timer_para) + 1);
    end else begin
      tcnt   = 0;
      timeup = 1'b0;
    end
  endtask

  task automatic cfg_write(input int addr, input int data, input bit taken);
    cfg_we   = 1'b1;
    cfg_addr = SEG_W'(addr);
    cfg_data = PARA_W'(data);
    tick();
    cfg_we = 1'b0;
    if (taken) tbl[addr] = PARA_W'(data);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ts"}, timer_start, 0);
    chk({tag, "_para"}, timer_para, 0);
    chk({tag, "_idx"}, seg_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_segd"}, seg_done, 0);
    chk({tag, "_scand"}, scan_done, 0);
    chk({tag, "_abrt"}, aborted, 0);
    chk({tag, "_left"}, scans_left, 0);
  endtask

  task automatic run(input int sc, input bit hold_go, input bit force_tu, input bit busy_wr,
                     input bit do_abort, input int ab_seg, input int ab_scan);
    int cyc, n_exp, n_sd, n_rise;
    bit fin, ts_prev;
    exp_idx.delete(); exp_para.delete(); exp_scn.delete();
    for (int s = sc; s >= 1; s--)
      for (int i = 0; i < NUM_SEG; i++)
        if (tbl[i] != 0) begin
          exp_idx.push_back(i); exp_para.push_back(int'(tbl[i])); exp_scn.push_back(s);
        end
    n_exp = exp_idx.size(); n_sd = 0; n_rise = 0; fin = 1'b0; ts_prev = 1'b0;
    scan_count = 16'(sc);
    go = 1'b1;
    tick();
    cyc = 1;
    if (!hold_go) go = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_scans_left", scans_left, sc);
    chk("go_seg_idx", seg_idx, 0);
    timer_step();
    if (force_tu) timeup = 1'b1;
    while (!fin && cyc < 3000) begin
      if (busy_wr && cyc == 6) begin
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 16'd9;
      end
      if (do_abort && timer_start && int'(seg_idx) == ab_seg && int'(scans_left) == ab_scan)
        abort = 1'b1;
      tick();
      cyc++;
      cfg_we = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_ts", timer_start, 0);
        chk("abort_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_no_scan_done", scan_done, 0);
        chk("abort_no_seg_done", seg_done, 0);
        tick();
        chk("abort_pulse_end", aborted, 0);
        chk("abort_stays_idle", busy, 0);
        fin = 1'b1;
      end else begin
        if (cyc == 3) chk("arm_latency", timer_start, tbl[0] != 0);
        if (timer_start && !ts_prev) begin
          n_rise++;
          chk("arm_para_avail", exp_para.size() != 0, 1);
          if (exp_para.size() != 0) chk("arm_para", timer_para, exp_para[0]);
        end
        if (seg_done) begin
          n_sd++;
          chk("seg_done_expected", exp_idx.size() != 0, 1);
          chk("seg_done_ts_low", timer_start, 0);
          if (exp_idx.size() != 0) begin
            chk("seg_done_idx", seg_idx, exp_idx.pop_front());
            chk("seg_done_para", timer_para, exp_para.pop_front());
            chk("seg_done_scans", scans_left, exp_scn.pop_front());
          end
        end
        if (scan_done) begin
          chk("scan_done_segs", n_sd, n_exp);
          chk("scan_done_arms", n_rise, n_exp);
          chk("scan_done_busy", busy, 0);
          chk("scan_done_left", scans_left, 0);
          done_cyc = cyc;
          fin = 1'b1;
        end
      end
      ts_prev = timer_start;
      timer_step();
    end
    chk("run_terminated", fin, 1);
    go = 1'b0;
    timeup = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; scan_count = '0;
    go = 1'b0; abort = 1'b0; timeup = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) tbl[i] = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // T1: basic single scan
    cfg_write(0, 3, 1); cfg_write(1, 5, 1); cfg_write(2, 2, 1); cfg_write(3, 4, 1);
    run(1, 0, 0, 0, 0, 0, 0);

    // T5: zero scan_count and abort in IDLE are ignored; timer_para holds last value
    scan_count = 16'd0; go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_zero_busy", busy, 0);
    chk("go_zero_left", scans_left, 0);
    chk("go_zero_idx", seg_idx, NUM_SEG - 1);
    chk("idle_para_hold", timer_para, tbl[NUM_SEG-1]);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_pulse", aborted, 0);
    chk("idle_no_scan_done", scan_done, 0);
    run(2, 1, 1, 0, 0, 0, 0);

    // T2: skipped segments over three scans
    cfg_write(0, 1, 1); cfg_write(1, 0, 1); cfg_write(2, 0, 1); cfg_write(3, 2, 1);
    run(3, 0, 0, 0, 0, 0, 0);

    // T3: abort in WAIT of segment 2 during second scan, then restart
    cfg_write(0, 1, 1); cfg_write(1, 2, 1); cfg_write(2, 3, 1); cfg_write(3, 4, 1);
    run(3, 0, 0, 0, 1, 2, 2);
    run(3, 0, 0, 0, 0, 0, 0);

    // T4: writes while busy are dropped, writes while idle land
    run(1, 0, 0, 1, 0, 0, 0);
    run(1, 0, 0, 0, 0, 0, 0);
    cfg_write(1, 9, 1);
    run(1, 0, 0, 0, 0, 0, 0);

    // Randomized tables and scan counts
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NUM_SEG; i++)
        cfg_write(i, ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6)), 1);
      run(int'($urandom_range(1, 3)), 0, 0, 0, 0, 0, 0);
    end

    // T6: reset mid-WAIT clears everything including the table
    cfg_write(0, 3, 1); cfg_write(1, 5, 1); cfg_write(2, 2, 1); cfg_write(3, 4, 1);
    scan_count = 16'd2; go = 1'b1;
    tick();
    go = 1'b0;
    timer_step();
    for (int k = 0; k < 50 && !timer_start; k++) begin
      tick();
      timer_step();
    end
    chk("t6_reached_wait", timer_start, 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    rst_n = 1'b1;
    timeup = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) tbl[i] = '0;
    run(2, 0, 0, 0, 0, 0, 0);
    chk("all_skip_len", done_cyc - 1, 2 * NUM_SEG * 2 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
